// File: rtl/lru_state_array_pkg.sv
// ---------------------------------------------------------------------------
// cache_types
// Shared cache types and helper functions for the tree pseudo-LRU state
// array of a 4-way set-associative cache.
//
// Contents:
//   lru_t          3-bit PLRU state {bit2 = c/d leaf, bit1 = a/b leaf, bit0 = root}
//   way_t          2-bit way number, 0=a 1=b 2=c 3=d
//   LRU_RESET      state of a freshly reset set (victim a)
//   lru_update()   new PLRU bits after an access to a way
//   plru_victim()  way selected by the PLRU tree alone
// ---------------------------------------------------------------------------
package cache_types;

    typedef logic [2:0] lru_t;
    typedef logic [1:0] way_t;

    localparam lru_t LRU_RESET = 3'b000;

    // An access makes the root and the accessed pair's leaf point away from
    // the accessed way. The other pair's leaf is left untouched.
    function automatic lru_t lru_update(input lru_t cur, input way_t way);
        lru_t nxt;
        nxt = cur;
        case (way)
            2'd0: begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            2'd1: begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            2'd2: begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
        endcase
        return nxt;
    endfunction

    // Walk the tree: the root picks a pair, the pair's leaf picks a way.
    function automatic way_t plru_victim(input lru_t bits);
        way_t way;
        if (bits[0] == 1'b0) begin
            way = bits[1] ? 2'd1 : 2'd0;
        end else begin
            way = bits[2] ? 2'd3 : 2'd2;
        end
        return way;
    endfunction

endpackage

// File: rtl/lru_state_array_victim_sel.sv
// ---------------------------------------------------------------------------
// lru_victim_sel
// Chooses the way to replace in one set. An empty (invalid) way is always
// preferred over evicting live data, so the lowest-numbered invalid way wins;
// only a fully valid set falls back to the PLRU tree.
//
// Ports:
//   lru_i            PLRU bits of the set being looked up
//   valid_i          valid bits of ways a..d (bit 0 = way a)
//   victim_way_o     way number to replace
//   victim_onehot_o  same choice as a one-hot vector, bit 0 = way a
// ---------------------------------------------------------------------------
module lru_victim_sel
    import cache_types::*;
(
    input  lru_t       lru_i,
    input  logic [3:0] valid_i,
    output way_t       victim_way_o,
    output logic [3:0] victim_onehot_o
);

    // Invalid ways override the PLRU choice, lowest index first.
    always_comb begin
        victim_way_o = plru_victim(lru_i);
        if (!valid_i[0]) begin
            victim_way_o = 2'd0;
        end else if (!valid_i[1]) begin
            victim_way_o = 2'd1;
        end else if (!valid_i[2]) begin
            victim_way_o = 2'd2;
        end else if (!valid_i[3]) begin
            victim_way_o = 2'd3;
        end
    end

    // Derived from the encoded way so the two forms can never disagree.
    assign victim_onehot_o = 4'b0001 << victim_way_o;

endmodule

// File: rtl/lru_state_array.sv
// ---------------------------------------------------------------------------
// lru_state_array
// Per-set tree pseudo-LRU state for a 4-way cache, held in a register array
// with a zero-latency combinational read port and a one-cycle write port.
//
// Parameters:
//   num_sets       number of sets (power of two, 2..256)
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset, clears every set to 3'b000
//   rd_index       set being looked up this cycle
//   rd_valid_ways  valid bits of ways a..d of the looked-up set
//   upd_en         record an access (hit or fill) this cycle
//   upd_index      set of the recorded access
//   upd_way        way accessed, 0=a 1=b 2=c 3=d
//   lru_sel        PLRU bits of rd_index {c/d leaf, a/b leaf, root}
//   victim_way     way to replace in rd_index
//   victim_onehot  one-hot form of victim_way
//
// Configuration:
//   LRU_BYPASS_EN  when defined, an update to the set being read this cycle
//                  is forwarded, so all outputs show the post-update bits.
//                  When undefined, the outputs show the stored bits.
// ---------------------------------------------------------------------------
module lru_state_array
    import cache_types::*;
#(
    parameter  int num_sets = 8,
    localparam int idx_w    = $clog2(num_sets)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [idx_w-1:0] rd_index,
    input  logic [3:0]       rd_valid_ways,
    input  logic             upd_en,
    input  logic [idx_w-1:0] upd_index,
    input  logic [1:0]       upd_way,
    output logic [2:0]       lru_sel,
    output logic [1:0]       victim_way,
    output logic [3:0]       victim_onehot
);

    lru_t lru_q [num_sets];
    lru_t lru_d [num_sets];
    lru_t updBits;
    lru_t rdBits;

    // New bits for the set being accessed, shared by the write port and the
    // optional forwarding path.
    assign updBits = lru_update(lru_q[upd_index], upd_way);

    // Only the addressed set changes; every other set holds its value.
    always_comb begin
        lru_d = lru_q;
        if (upd_en) begin
            lru_d[upd_index] = updBits;
        end
    end

    // Reset takes priority over any simultaneous update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < num_sets; i++) begin
                lru_q[i] <= LRU_RESET;
            end
        end else begin
            lru_q <= lru_d;
        end
    end

`ifdef LRU_BYPASS_EN
    // Forward a same-cycle update to the set being read.
    always_comb begin
        rdBits = lru_q[rd_index];
        if (upd_en && (upd_index == rd_index)) begin
            rdBits = updBits;
        end
    end
`else
    // Plain read of the stored bits; a same-cycle update is seen next cycle.
    always_comb begin
        rdBits = lru_q[rd_index];
    end
`endif

    assign lru_sel = rdBits;

    lru_victim_sel u_victim_sel (
        .lru_i           (rdBits),
        .valid_i         (rd_valid_ways),
        .victim_way_o    (victim_way),
        .victim_onehot_o (victim_onehot)
    );

endmodule

// File: tb/tb_lru_state_array.sv
// ---------------------------------------------------------------------------
// tb_lru_state_array
// Self-checking bench for lru_state_array (num_sets = 8). A directed sequence
// with hand-computed expectations is followed by a long random sequence whose
// expectations come from an independent 4-way PLRU model. The stimulus side
// queues the expected outputs for each checked cycle; a monitor on the
// falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_lru_state_array;

    localparam int NUM_SETS = 8;

`ifdef LRU_BYPASS_EN
    localparam logic [2:0] SAME2_LRU = 3'b110;
    localparam logic [1:0] SAME2_WAY = 2'd1;
    localparam logic [3:0] SAME2_OH  = 4'b0010;
    localparam logic [2:0] SAME4_LRU = 3'b001;
    localparam logic [1:0] SAME4_WAY = 2'd2;
    localparam logic [3:0] SAME4_OH  = 4'b0100;
    localparam bit         BYPASS    = 1'b1;
`else
    localparam logic [2:0] SAME2_LRU = 3'b011;
    localparam logic [1:0] SAME2_WAY = 2'd2;
    localparam logic [3:0] SAME2_OH  = 4'b0100;
    localparam logic [2:0] SAME4_LRU = 3'b000;
    localparam logic [1:0] SAME4_WAY = 2'd0;
    localparam logic [3:0] SAME4_OH  = 4'b0001;
    localparam bit         BYPASS    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rdIndex;
    logic [3:0] rdValidWays;
    logic       updEn;
    logic [2:0] updIndex;
    logic [1:0] updWay;
    logic [2:0] lruSel;
    logic [1:0] victimWay;
    logic [3:0] victimOnehot;

    logic       expectValid = 1'b0;
    logic [2:0] expLruQ [$];
    logic [1:0] expWayQ [$];
    logic [3:0] expOhQ  [$];
    string      expNameQ [$];
    logic [2:0] model [NUM_SETS];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lru_state_array #(.num_sets(NUM_SETS)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_index      (rdIndex),
        .rd_valid_ways (rdValidWays),
        .upd_en        (updEn),
        .upd_index     (updIndex),
        .upd_way       (updWay),
        .lru_sel       (lruSel),
        .victim_way    (victimWay),
        .victim_onehot (victimOnehot)
    );

    // Reference PLRU behaviour, written from the tree description.
    function automatic logic [2:0] modelNext(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (w == 2'd0) r = {b[2], 1'b1, 1'b1};
        if (w == 2'd1) r = {b[2], 1'b0, 1'b1};
        if (w == 2'd2) r = {1'b1, b[1], 1'b0};
        if (w == 2'd3) r = {1'b0, b[1], 1'b0};
        return r;
    endfunction

    function automatic logic [1:0] modelVictim(input logic [2:0] b, input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) return 2'(i);
        end
        if (b[0]) return b[2] ? 2'd3 : 2'd2;
        return b[1] ? 2'd1 : 2'd0;
    endfunction

    // Drive one cycle of inputs and, when chk is set, queue what the DUT
    // must show during that cycle. The model then absorbs the cycle's write.
    task automatic applyStimulus(input string name, input logic [2:0] ri, input logic [3:0] vv,
                                 input logic ue, input logic [2:0] ui, input logic [1:0] uw,
                                 input logic rs, input logic chk, input logic [2:0] eLru,
                                 input logic [1:0] eWay, input logic [3:0] eOh);
        @(posedge clk);
        #1;
        rst         = rs;
        rdIndex     = ri;
        rdValidWays = vv;
        updEn       = ue;
        updIndex    = ui;
        updWay      = uw;
        expectValid = chk;
        if (chk) begin
            expNameQ.push_back(name);
            expLruQ.push_back(eLru);
            expWayQ.push_back(eWay);
            expOhQ.push_back(eOh);
        end
        if (rs) begin
            for (int i = 0; i < NUM_SETS; i++) model[i] = 3'b000;
        end else if (ue) begin
            model[ui] = modelNext(model[ui], uw);
        end
    endtask

    task automatic checkOutput();
        string      name;
        logic [2:0] eLru;
        logic [1:0] eWay;
        logic [3:0] eOh;
        checks++;
        if (expLruQ.size() == 0) begin
            $display("[TB] FAIL unexpected_output: queue empty, lru_sel=%b victim_way=%0d", lruSel, victimWay);
        end else begin
            name = expNameQ.pop_front();
            eLru = expLruQ.pop_front();
            eWay = expWayQ.pop_front();
            eOh  = expOhQ.pop_front();
            if (lruSel === eLru && victimWay === eWay && victimOnehot === eOh) begin
                passes++;
            end else begin
                $display("[TB] FAIL %s: got lru_sel=%b victim_way=%0d victim_onehot=%b, want %b %0d %b",
                         name, lruSel, victimWay, victimOnehot, eLru, eWay, eOh);
            end
        end
    endtask

    always @(negedge clk) begin
        if (expectValid) checkOutput();
    end

    initial begin
        logic [2:0] ri, ui, cur;
        logic [3:0] vv;
        logic       ue;
        logic [1:0] uw, ew;

        rst = 1'b1; rdIndex = '0; rdValidWays = 4'hF; updEn = 1'b0; updIndex = '0; updWay = '0;
        for (int i = 0; i < NUM_SETS; i++) model[i] = 3'b000;

        // Reset with a simultaneous update to set 6 that must be dropped.
        applyStimulus("rst", 3'd0, 4'hF, 1'b1, 3'd6, 2'd0, 1'b1, 1'b0, 3'b000, 2'd0, 4'b0001);
        applyStimulus("rst", 3'd0, 4'hF, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 3'b000, 2'd0, 4'b0001);

        for (int i = 0; i < NUM_SETS; i++) begin
            applyStimulus("reset_state", 3'(i), 4'hF, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        end
        applyStimulus("read_idx5",     3'd5, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("upd2_a",        3'd0, 4'hF,    1'b1, 3'd2, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("upd2_c_same",   3'd2, 4'hF,    1'b1, 3'd2, 2'd2, 1'b0, 1'b1, SAME2_LRU, SAME2_WAY, SAME2_OH);
        applyStimulus("set2_after",    3'd2, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b110, 2'd1, 4'b0010);
        applyStimulus("invalid_over",  3'd3, 4'b1011, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b000, 2'd2, 4'b0100);
        applyStimulus("upd4_b_same",   3'd4, 4'hF,    1'b1, 3'd4, 2'd1, 1'b0, 1'b1, SAME4_LRU, SAME4_WAY, SAME4_OH);
        applyStimulus("set4_after",    3'd4, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b001, 2'd2, 4'b0100);
        applyStimulus("set6_rst_drop", 3'd6, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("set7_iso_a",    3'd7, 4'hF,    1'b1, 3'd6, 2'd2, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("set7_iso_b",    3'd7, 4'hF,    1'b1, 3'd6, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("set6_leaf",     3'd6, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b111, 2'd3, 4'b1000);
        applyStimulus("set7_iso_c",    3'd7, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0001);
        applyStimulus("inv_a",         3'd2, 4'b1110, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b110, 2'd0, 4'b0001);
        applyStimulus("inv_d",         3'd2, 4'b0111, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b110, 2'd3, 4'b1000);
        applyStimulus("all_invalid",   3'd6, 4'b0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b111, 2'd0, 4'b0001);
        applyStimulus("inv_b",         3'd6, 4'b1101, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b111, 2'd1, 4'b0010);
        applyStimulus("upd_en_low",    3'd2, 4'hF,    1'b0, 3'd2, 2'd3, 1'b0, 1'b1, 3'b110, 2'd1, 4'b0010);
        applyStimulus("upd_en_low2",   3'd2, 4'hF,    1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b110, 2'd1, 4'b0010);

        // Random traffic against the reference model.
        for (int n = 0; n < 10000; n++) begin
            ri = 3'($urandom_range(0, NUM_SETS - 1));
            ui = 3'($urandom_range(0, NUM_SETS - 1));
            if ($urandom_range(0, 3) == 0) ui = ri;
            uw = 2'($urandom_range(0, 3));
            ue = 1'($urandom_range(0, 1));
            vv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            cur = model[ri];
            if (BYPASS && ue && (ui == ri)) cur = modelNext(model[ui], uw);
            ew = modelVictim(cur, vv);
            applyStimulus("random", ri, vv, ue, ui, uw, 1'b0, 1'b1, cur, ew, 4'(4'b0001 << ew));
        end

        @(posedge clk);
        #1;
        expectValid = 1'b0;
        updEn = 1'b0;
        @(negedge clk);
        checks++;
        if (expLruQ.size() == 0) passes++;
        else $display("[TB] FAIL drain: %0d expectations left, want 0", expLruQ.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
